// File: rtl/lat_cmd_pkg.sv
// rtl/lat_cmd_pkg.sv - command codes, FSM states and LAT width table for the LAT sequencer
package lat_cmd_pkg;

    typedef enum logic [2:0] {
        CMD_WRTGS     = 3'd0,
        CMD_LATGS     = 3'd1,
        CMD_WRTFC     = 3'd2,
        CMD_LINERESET = 3'd3,
        CMD_READFC    = 3'd4,
        CMD_TMGRST    = 3'd5
    } lat_cmd_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        SHIFT  = 2'd2,
        TAIL   = 2'd3
    } seq_state_e;

    localparam int SHIFT_BITS_DEF  = 48;
    localparam int FCWRTEN_LEN_DEF = 15;
    localparam int GAP_LEN_DEF     = 1;
    localparam int LAT_WIDTH_MAX   = 13;

    // Number of SCLK posedges LAT stays high at the end of the shift window.
    function automatic int unsigned lat_width(input lat_cmd_e c);
        case (c)
            CMD_WRTGS:     return 1;
            CMD_LATGS:     return 3;
            CMD_WRTFC:     return 5;
            CMD_LINERESET: return 7;
            CMD_READFC:    return 11;
            CMD_TMGRST:    return 13;
            default:       return 1;
        endcase
    endfunction

endpackage

// File: rtl/lat_cmd_sequencer_sclk_posedge_det.sv
// rtl/lat_cmd_sequencer_sclk_posedge_det.sv - SCLK rising-edge detector in the clk domain
module sclk_posedge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    output logic o_posedge
);

    logic r_prev_sclk;

    // Resetting to 1 keeps an SCLK that is already high at release from looking like an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_sclk <= 1'b1;
        end else begin
            r_prev_sclk <= i_sclk;
        end
    end

    assign o_posedge = i_sclk & ~r_prev_sclk;

endmodule

// File: rtl/lat_cmd_sequencer.sv
// rtl/lat_cmd_sequencer.sv - LAT framing sequencer for TLC5957-style driver chains
module lat_cmd_sequencer
    import lat_cmd_pkg::*;
#(
    parameter int SHIFT_BITS  = SHIFT_BITS_DEF,
    parameter int N_CHAIN     = 1,
    parameter int FCWRTEN_LEN = FCWRTEN_LEN_DEF,
    parameter int GAP_LEN     = GAP_LEN_DEF,
    parameter int CNT_W       = $clog2(((SHIFT_BITS * N_CHAIN) > (FCWRTEN_LEN + GAP_LEN) ?
                                        (SHIFT_BITS * N_CHAIN) : (FCWRTEN_LEN + GAP_LEN)) + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCLK,
    input  logic             start,
    input  logic [2:0]       cmd,
    input  logic             abort,
    output logic             en,
    output logic             LAT,
    output logic             shift_phase,
    output logic [CNT_W-1:0] bit_idx,
    output logic             done,
    output logic             cmd_err
);

    localparam int TOTAL = SHIFT_BITS * N_CHAIN;
    localparam logic [CNT_W-1:0] L_SHIFT_LAST  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] L_PREFIX_LAST = CNT_W'(FCWRTEN_LEN + GAP_LEN - 1);
    localparam logic [CNT_W-1:0] L_PREFIX_LAT  = CNT_W'(FCWRTEN_LEN);

    if (LAT_WIDTH_MAX > TOTAL) begin : g_bad_total
        $error("lat_cmd_sequencer: shift frame shorter than the widest LAT pulse");
    end
    if (FCWRTEN_LEN < 1) begin : g_bad_fcwrten
        $error("lat_cmd_sequencer: FCWRTEN_LEN must be at least 1");
    end

    seq_state_e       r_state;
    lat_cmd_e         r_cmd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;
    logic             r_cmd_err;
    logic             w_sclk_pos;
    logic             w_cmd_valid;
    logic [CNT_W-1:0] w_lat_thresh;

    sclk_posedge_det u_sclk_det (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_sclk    (SCLK),
        .o_posedge (w_sclk_pos)
    );

    assign w_cmd_valid  = (cmd < 3'd6);
    assign w_lat_thresh = CNT_W'(TOTAL - int'(lat_width(r_cmd)));

    // Abort outranks every transition, including a start arriving in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cmd     <= CMD_WRTGS;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;
            if (abort) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            if (w_cmd_valid) begin
                                r_cmd   <= lat_cmd_e'(cmd);
                                r_cnt   <= '0;
                                r_state <= (lat_cmd_e'(cmd) == CMD_WRTFC) ? PREFIX : SHIFT;
                            end else begin
                                r_cmd_err <= 1'b1;
                            end
                        end
                    end
                    PREFIX: begin
                        if (w_sclk_pos) begin
                            if (r_cnt == L_PREFIX_LAST) begin
                                r_state <= SHIFT;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    SHIFT: begin
                        if (w_sclk_pos) begin
                            if (r_cnt == L_SHIFT_LAST) begin
                                r_state <= TAIL;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    TAIL: begin
                        if (w_sclk_pos) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        LAT = 1'b0;
        case (r_state)
            PREFIX:  LAT = (r_cnt < L_PREFIX_LAT);
            SHIFT:   LAT = (r_cnt >= w_lat_thresh);
            default: LAT = 1'b0;
        endcase
    end

    assign en          = (r_state != IDLE);
    assign shift_phase = (r_state == SHIFT);
    assign bit_idx     = shift_phase ? (L_SHIFT_LAST - r_cnt) : '0;
    assign done        = r_done;
    assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_lat_cmd_sequencer.sv
// tb/tb_lat_cmd_sequencer.sv - self-checking bench for lat_cmd_sequencer
module tb_lat_cmd_sequencer;

    typedef struct packed {
        logic       en;
        logic       lat;
        logic       sp;
        logic [6:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCLK = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic [2:0] cmd1 = 3'd0;
    logic [2:0] cmd2 = 3'd0;
    logic       abort1 = 1'b0;

    logic       en1, lat1, sp1, done1, err1;
    logic [5:0] idx1;
    logic       en2, lat2, sp2, done2, err2;
    logic [6:0] idx2;

    int checks = 0;
    int failures = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    int lat_cnt = 0;
    int lat_shift_cnt = 0;
    int pos_n = 0;
    int mon_sel = 0;
    int wtab [6] = '{1, 3, 5, 7, 11, 13};

    exp_t exp_q [$];
    exp_t m_e;
    exp_t m_a;

    lat_cmd_sequencer u_dut1 (
        .clk(clk), .rst(rst), .SCLK(SCLK), .start(start1), .cmd(cmd1), .abort(abort1),
        .en(en1), .LAT(lat1), .shift_phase(sp1), .bit_idx(idx1), .done(done1), .cmd_err(err1)
    );

    lat_cmd_sequencer #(.N_CHAIN(2)) u_dut2 (
        .clk(clk), .rst(rst), .SCLK(SCLK), .start(start2), .cmd(cmd2), .abort(1'b0),
        .en(en2), .LAT(lat2), .shift_phase(sp2), .bit_idx(idx2), .done(done2), .cmd_err(err2)
    );

    always #5 clk = ~clk;
    always #20 SCLK = ~SCLK;

    always @(negedge clk) begin
        if (done1) done_cnt1++;
        if (done2) done_cnt2++;
    end

    always @(posedge SCLK) begin
        if (exp_q.size() != 0) begin
            m_e = exp_q.pop_front();
            m_a = (mon_sel != 0) ? {en2, lat2, sp2, idx2} : {en1, lat1, sp1, 1'b0, idx1};
            pos_n++;
            checks++;
            if (m_a !== m_e) begin
                failures++;
                $display("FAIL posedge_%0d sample: got en/lat/sp/idx=%b/%b/%b/%0d want %b/%b/%b/%0d",
                         pos_n, m_a.en, m_a.lat, m_a.sp, m_a.idx, m_e.en, m_e.lat, m_e.sp, m_e.idx);
            end
            if (m_a.lat) lat_cnt++;
            if (m_a.lat && m_a.sp) lat_shift_cnt++;
        end
    end

    task automatic issue(input int sel, input logic [2:0] c);
        @(negedge clk);
        if (sel == 0) begin start1 = 1'b1; cmd1 = c; end
        else begin start2 = 1'b1; cmd2 = c; end
        @(posedge clk); #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic arm_frame(input int sel, input logic [2:0] c);
        int total;
        total = (sel == 0) ? 48 : 96;
        lat_cnt = 0;
        lat_shift_cnt = 0;
        pos_n = 0;
        if (c == 3'd2) begin
            for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, (k < 15), 1'b0, 7'd0});
        end
        for (int i = 0; i < total; i++)
            exp_q.push_back({1'b1, (i >= total - wtab[int'(c)]), 1'b1, 7'(total - 1 - i)});
        exp_q.push_back({1'b1, 1'b0, 1'b0, 7'd0});
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d samples left want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_frame(input int sel, input string name);
        logic d, e;
        wait_empty(name);
        d = (sel == 0) ? done1 : done2;
        e = (sel == 0) ? en1 : en2;
        checks++;
        if ({d, e} !== 2'b10) begin
            failures++;
            $display("FAIL %s_done: got done/en=%b/%b want 1/0", name, d, e);
        end
        @(posedge clk); #1;
        d = (sel == 0) ? done1 : done2;
        checks++;
        if (d !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse: got done=%b want 0", name, d);
        end
    endtask

    task automatic run_frame(input int sel, input logic [2:0] c, input string name);
        mon_sel = sel;
        issue(sel, c);
        arm_frame(sel, c);
        wait_frame(sel, name);
    endtask

    task automatic test_reset;
        start1 = 1'b1;
        cmd1 = 3'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({en1, lat1, sp1, idx1, done1, err1} !== 11'd0) begin
            failures++;
            $display("FAIL reset_dut1: got %b want 0", {en1, lat1, sp1, idx1, done1, err1});
        end
        checks++;
        if ({en2, lat2, sp2, idx2, done2, err2} !== 12'd0) begin
            failures++;
            $display("FAIL reset_dut2: got %b want 0", {en2, lat2, sp2, idx2, done2, err2});
        end
        rst = 1'b0;
        start1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (en1 !== 1'b0) begin
            failures++;
            $display("FAIL reset_start_ignored: got en=%b want 0", en1);
        end
    endtask

    task automatic test_wrtfc;
        run_frame(0, 3'd2, "wrtfc");
        checks++;
        if (lat_cnt != 20 || pos_n != 65) begin
            failures++;
            $display("FAIL wrtfc_counts: got lat_high=%0d posedges=%0d want 20/65", lat_cnt, pos_n);
        end
    endtask

    task automatic test_latgs_chain2;
        run_frame(1, 3'd1, "latgs_chain2");
        checks++;
        if (lat_cnt != 3 || pos_n != 97) begin
            failures++;
            $display("FAIL latgs_chain2_counts: got lat_high=%0d posedges=%0d want 3/97", lat_cnt, pos_n);
        end
    endtask

    task automatic test_sweep;
        for (int c = 0; c < 6; c++) begin
            run_frame(0, 3'(c), "sweep");
            checks++;
            if (lat_shift_cnt != wtab[c]) begin
                failures++;
                $display("FAIL sweep_lat_width cmd=%0d: got %0d want %0d", c, lat_shift_cnt, wtab[c]);
            end
        end
        for (int c = 6; c < 8; c++) begin
            issue(0, 3'(c));
            checks++;
            if ({err1, en1} !== 2'b10) begin
                failures++;
                $display("FAIL cmd_err_%0d: got err/en=%b/%b want 1/0", c, err1, en1);
            end
            @(posedge clk); #1;
            checks++;
            if ({err1, en1} !== 2'b00) begin
                failures++;
                $display("FAIL cmd_err_pulse_%0d: got err/en=%b/%b want 0/0", c, err1, en1);
            end
        end
    endtask

    task automatic test_back_to_back;
        int base;
        base = done_cnt1;
        mon_sel = 0;
        @(negedge clk);
        start1 = 1'b1;
        cmd1 = 3'd0;
        @(posedge clk); #1;
        cmd1 = 3'd5;
        arm_frame(0, 3'd0);
        wait_frame(0, "b2b_first");
        start1 = 1'b0;
        checks++;
        if (done_cnt1 != base + 1 || en1 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: got dones=%0d en=%b want %0d/1", done_cnt1 - base, en1, 1);
        end
        arm_frame(0, 3'd5);
        wait_frame(0, "b2b_second");
        checks++;
        if (lat_shift_cnt != 13) begin
            failures++;
            $display("FAIL b2b_second_width: got %0d want 13", lat_shift_cnt);
        end
    endtask

    task automatic test_abort;
        int base;
        mon_sel = 0;
        issue(0, 3'd0);
        arm_frame(0, 3'd0);
        while (exp_q.size() > 20) void'(exp_q.pop_back());
        wait_empty("abort_lead");
        checks++;
        if ({en1, sp1, idx1} !== {1'b1, 1'b1, 6'd27}) begin
            failures++;
            $display("FAIL abort_cnt20: got en/sp/idx=%b/%b/%0d want 1/1/27", en1, sp1, idx1);
        end
        base = done_cnt1;
        abort1 = 1'b1;
        @(posedge clk); #1;
        abort1 = 1'b0;
        checks++;
        if ({en1, lat1, sp1, idx1} !== 9'd0) begin
            failures++;
            $display("FAIL abort_outputs: got %b want 0", {en1, lat1, sp1, idx1});
        end
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (done_cnt1 != base || en1 !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got dones=%0d en=%b want 0/0", done_cnt1 - base, en1);
        end
        @(negedge clk);
        abort1 = 1'b1;
        start1 = 1'b1;
        cmd1 = 3'd1;
        @(posedge clk); #1;
        abort1 = 1'b0;
        start1 = 1'b0;
        checks++;
        if (en1 !== 1'b0) begin
            failures++;
            $display("FAIL abort_start_idle: got en=%b want 0", en1);
        end
        run_frame(0, 3'd0, "after_abort");
    endtask

    task automatic test_reset_mid;
        mon_sel = 0;
        issue(0, 3'd2);
        arm_frame(0, 3'd2);
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        wait_empty("rst_lead");
        checks++;
        if ({en1, lat1} !== 2'b11) begin
            failures++;
            $display("FAIL rst_prefix_lat: got en/lat=%b/%b want 1/1", en1, lat1);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({en1, lat1, sp1, idx1, done1, err1} !== 11'd0) begin
            failures++;
            $display("FAIL rst_async: got %b want 0", {en1, lat1, sp1, idx1, done1, err1});
        end
        @(posedge SCLK);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (en1 !== 1'b0) begin
            failures++;
            $display("FAIL rst_release_idle: got en=%b want 0", en1);
        end
        run_frame(0, 3'd2, "after_rst");
    endtask

    initial begin
        test_reset();
        test_wrtfc();
        test_latgs_chain2();
        test_sweep();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
